dmem_dual_responder: RTL and testbench
======================================

// Module: dmem_dual_responder
// PURPOSE
//  Memory-side responder for the dual-issue core's MEM stage: accepts one load/store per slot per cycle.
//  Slot1 is program-older than slot2. Storage is two single-port banks interleaved on word-address bit 0.
//  Same-bank bundles are serialised over two cycles, with a combinational stall back to the MEM stage.
//  Read data for both slots returns together, registered, one cycle after the bundle completes.
// PARAMETERS
//  DATA_W   32    data word width
//  ADDR_W   10    word address width; total depth 2**ADDR_W, each bank 2**(ADDR_W-1)
//  CNT_W    16    width of conflict performance counter
// PORTS
//  clk           in   1        single clock, all state on rising edge
//  rst           in   1        asynchronous, active-low reset
//  req1_valid    in   1        slot1 request present
//  req1_we       in   1        slot1 store (1) / load (0)
//  req1_addr     in   ADDR_W   slot1 word address
//  req1_wdata    in   DATA_W   slot1 store data (forwarded value already resolved)
//  req2_valid    in   1        slot2 request present
//  req2_we       in   1        slot2 store / load
//  req2_addr     in   ADDR_W   slot2 word address
//  req2_wdata    in   DATA_W   slot2 store data
//  stall         out  1        hold MEM/WB and upstream; requester keeps req* stable while high
//  rsp_valid     out  1        rdata1/rdata2 valid for the bundle completed last cycle
//  rdata1        out  DATA_W   slot1 load data (0 if slot1 was a store or invalid)
//  rdata2        out  DATA_W   slot2 load data (0 if slot2 was a store or invalid)
//  conflict_cnt  out  CNT_W    number of serialised bundles, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; stall=0, rsp_valid=0, rdata1/2=0, conflict_cnt=0. Bank contents are not cleared.
//  - bank(a) = a[0]; row(a) = a[ADDR_W-1:1].
//  - conflict = req1_valid & req2_valid & bank(a1)==bank(a2) & ~(~we1 & ~we2 & a1==a2).
//  - IDLE, no conflict: both valid slots access their banks this cycle (stall=0).
//    A two-read, same-address bundle is merged into one bank read; both rdata carry that value.
//    Next cycle: rsp_valid=1 with both rdata.
//  - IDLE, conflict: stall=1 (combinational, same cycle). Slot1 accesses its bank; its read data is captured
//    into a hold register. conflict_cnt+1 (saturates at all-ones). Next state is SECOND.
//  - SECOND: stall=0; slot2 accesses its bank. Next state is IDLE. Next cycle: rsp_valid=1, rdata1=held value,
//    rdata2=bank data.
//  - Ordering: serialisation guarantees a slot1 store followed by a slot2 load to the same address returns the
//    new data. For two stores to the same address, slot2's value is final (written last).
//  - Load latency 1 cycle after completing access; banks are read-first w.r.t. a same-cycle write to another row
//    only — no bank ever sees two accesses in one cycle.
//  - rsp_valid is a 1-cycle pulse per completed bundle containing at least one valid slot.
//    rdata holds its value until the next pulse.
//  - Bundle with no valid slot: no access, no rsp_valid.
//  - Invalid slot never writes; its rdata returns 0.
//  - Addresses are exactly ADDR_W bits; there is no out-of-range case.
//  - Reset asserted in SECOND: aborts the slot2 access; slot1's store, already written, persists.
//    stall drops immediately.
//  - The requester must not change req* while stall=1. Behaviour is undefined if it does.
// STRUCTURE
//  - Shared package dmem_pkg: state encoding (S_IDLE, S_SECOND), bank-select/row helper functions,
//    and default DATA_W/ADDR_W constants shared with the core top.
//  - Sub-module dmem_bank: single-port synchronous RAM, depth 2**(ADDR_W-1), inputs en/we/row/wdata,
//    registered rdata. Instantiated twice (bank0, bank1).
//  - Top contains the conflict detector, FSM, per-bank port muxes (slot select), hold register,
//    response registers, and counter.
// TESTING
//  1. Reset mid-stream: preload, assert rst low for 1 cycle during SECOND
//     -> stall=0, rsp_valid=0, rdata=0, conflict_cnt=0 immediately.
//  2. Split banks: st1 a=4 d=0xAAAA, st2 a=5 d=0x5555, then ld1 a=4, ld2 a=5
//     -> no stall; the load bundle's rsp_valid is followed by rdata1=0xAAAA, rdata2=0x5555.
//  3. Same-bank conflict: ld1 a=2, ld2 a=6 (mem[2]=0x11, mem[6]=0x22)
//     -> stall=1 for exactly 1 cycle; then rsp_valid with rdata1=0x11, rdata2=0x22; conflict_cnt=1.
//  4. Same-address RAW: st1 a=8 d=0xDEAD, ld2 a=8
//     -> 1 stall cycle, rdata2=0xDEAD, rdata1=0.
//  5. WAW plus merge: st1 a=3 d=1, st2 a=3 d=2, then ld1 a=3, ld2 a=3
//     -> first bundle stalls 1 cycle; second does not stall, rdata1=rdata2=2.
//  6. Counter saturation: CNT_W=4, issue 20 conflicting bundles -> conflict_cnt stops at 15.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-issue data-memory responder and the core top.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 10;

  // Responder sequencing: IDLE takes a new bundle, SECOND finishes a serialised one.
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  // Word address as seen by the interleaved banks: low bit picks the bank.
  typedef struct packed {
    logic [DMEM_ADDR_W-2:0] row;
    logic                   bank;
  } addr_split_t;

  function automatic logic bank_of(input logic [DMEM_ADDR_W-1:0] addr);
    addr_split_t s;
    s = addr_split_t'(addr);
    return s.bank;
  endfunction

  function automatic logic [DMEM_ADDR_W-2:0] row_of(input logic [DMEM_ADDR_W-1:0] addr);
    addr_split_t s;
    s = addr_split_t'(addr);
    return s.row;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM bank with registered read data.
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] rdata_q;

  // One access per cycle: write the row, or register its contents for the next cycle.
  // NOTE: storage and its read register carry no reset; a RAM macro cannot clear itself and nothing reads a row before it is loaded.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[row] <= wdata;
      end else begin
        rdata_q <= mem_q[row];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_dual_responder.sv
// MEM-stage responder for two load/store slots over two address-interleaved banks.
// Same-bank bundles are split over two cycles with a combinational stall.
module dmem_dual_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req2_valid,
  input  logic              req2_we,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int ROW_W = ADDR_W - 1;

  state_e              state_q, state_d;
  logic                bank1, bank2;
  logic                conflict, acc1, acc2, done;

  logic [1:0]          bank_en, bank_we;
  logic [ROW_W-1:0]    bank_row   [2];
  logic [DATA_W-1:0]   bank_wdata [2];
  logic [DATA_W-1:0]   bank_rdata [2];

  logic                rsp_valid_q, rsp_valid_d;
  logic                rd1_load_q, rd1_load_d;
  logic                rd1_hold_q, rd1_hold_d;
  logic                rd1_bank_q, rd1_bank_d;
  logic                rd2_load_q, rd2_load_d;
  logic                rd2_bank_q, rd2_bank_d;
  logic [DATA_W-1:0]   hold1_q, hold1_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [DATA_W-1:0]   rdata2_q, rdata2_d;
  logic [DATA_W-1:0]   rsp_data1, rsp_data2;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Conflict detection and which slots touch a bank this cycle; reset blocks every access.
  always_comb begin
    bank1    = req1_addr[0];
    bank2    = req2_addr[0];
    conflict = req1_valid && req2_valid && (bank1 == bank2) &&
               !(!req1_we && !req2_we && (req1_addr == req2_addr));
    stall    = rst && (state_q == S_IDLE) && conflict;
    acc1     = rst && req1_valid && (state_q == S_IDLE);
    acc2     = rst && req2_valid &&
               (((state_q == S_IDLE) && !conflict) || (state_q == S_SECOND));
    done     = rst && (((state_q == S_IDLE) && !conflict && (req1_valid || req2_valid)) ||
                       (state_q == S_SECOND));
  end

  // Per-bank port mux: slot1 wins the port; a shared port only happens for a merged same-address read.
  // NOTE: every output of a combinational block gets a default first so no path leaves it holding a stale value (no latch).
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_en[b]    = 1'b0;
      bank_we[b]    = 1'b0;
      bank_row[b]   = req2_addr[ADDR_W-1:1];
      bank_wdata[b] = req2_wdata;
      if (acc1 && (bank1 == 1'(b))) begin
        bank_en[b]    = 1'b1;
        bank_we[b]    = req1_we;
        bank_row[b]   = req1_addr[ADDR_W-1:1];
        bank_wdata[b] = req1_wdata;
      end else if (acc2 && (bank2 == 1'(b))) begin
        bank_en[b]    = 1'b1;
        bank_we[b]    = req2_we;
      end
    end
  end

  dmem_bank #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank0 (
    .clk   (clk),
    .en    (bank_en[0]),
    .we    (bank_we[0]),
    .row   (bank_row[0]),
    .wdata (bank_wdata[0]),
    .rdata (bank_rdata[0])
  );

  dmem_bank #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank1 (
    .clk   (clk),
    .en    (bank_en[1]),
    .we    (bank_we[1]),
    .row   (bank_row[1]),
    .wdata (bank_wdata[1]),
    .rdata (bank_rdata[1])
  );

  // Read-data selection in the response cycle; between pulses the last response is replayed.
  always_comb begin
    rsp_data1 = '0;
    rsp_data2 = '0;
    if (rd1_load_q) begin
      rsp_data1 = rd1_hold_q ? hold1_q : bank_rdata[rd1_bank_q];
    end
    if (rd2_load_q) begin
      rsp_data2 = bank_rdata[rd2_bank_q];
    end
    rdata1_d = rsp_valid_q ? rsp_data1 : rdata1_q;
    rdata2_d = rsp_valid_q ? rsp_data2 : rdata2_q;
  end

  // Next state, response bookkeeping, slot1 hold capture and saturating conflict counter.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = done;
    rd1_load_d  = rd1_load_q;
    rd1_hold_d  = rd1_hold_q;
    rd1_bank_d  = rd1_bank_q;
    rd2_load_d  = rd2_load_q;
    rd2_bank_d  = rd2_bank_q;
    hold1_d     = hold1_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE:   if (stall) state_d = S_SECOND;
      S_SECOND: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Slot1's read result sits on its bank output only during SECOND, before slot2 overwrites it.
    if (state_q == S_SECOND) begin
      hold1_d = bank_rdata[bank1];
    end
    if (done) begin
      rd1_load_d = req1_valid && !req1_we;
      rd1_hold_d = (state_q == S_SECOND);
      rd1_bank_d = bank1;
      rd2_load_d = req2_valid && !req2_we;
      rd2_bank_d = bank2;
    end
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Registered FSM state and response state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rd1_load_q  <= 1'b0;
      rd1_hold_q  <= 1'b0;
      rd1_bank_q  <= 1'b0;
      rd2_load_q  <= 1'b0;
      rd2_bank_q  <= 1'b0;
      hold1_q     <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rd1_load_q  <= rd1_load_d;
      rd1_hold_q  <= rd1_hold_d;
      rd1_bank_q  <= rd1_bank_d;
      rd2_load_q  <= rd2_load_d;
      rd2_bank_q  <= rd2_bank_d;
      hold1_q     <= hold1_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rdata1       = rdata1_d;
  assign rdata2       = rdata2_d;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_dual_responder.sv
// Directed bench for dmem_dual_responder with a response scoreboard.
module tb_dmem_dual_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req1_valid, req1_we, req2_valid, req2_we;
  logic [ADDR_W-1:0] req1_addr, req2_addr;
  logic [DATA_W-1:0] req1_wdata, req2_wdata;
  logic              stall, rsp_valid;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic [CNT_W-1:0]  conflict_cnt;

  typedef struct {
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
  } exp_t;

  exp_t              exp_q[$];
  int                vectors = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] last1 = '0;
  logic [DATA_W-1:0] last2 = '0;
  int                exp_cnt = 0;

  dmem_dual_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req1_valid   (req1_valid),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req2_valid   (req2_valid),
    .req2_we      (req2_we),
    .req2_addr    (req2_addr),
    .req2_wdata   (req2_wdata),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bundle just after a rising edge, count stall cycles, release after completion.
  task automatic bundle(input bit v1, input bit we1, input int a1, input logic [31:0] d1,
                        input bit v2, input bit we2, input int a2, input logic [31:0] d2,
                        input int exp_stalls, input logic [31:0] e1, input logic [31:0] e2);
    int n;
    req1_valid = v1;  req1_we = we1;  req1_addr = ADDR_W'(a1);  req1_wdata = d1;
    req2_valid = v2;  req2_we = we2;  req2_addr = ADDR_W'(a2);  req2_wdata = d2;
    if (v1 || v2) exp_q.push_back('{e1, e2});
    if (exp_stalls > 0 && exp_cnt < 15) exp_cnt++;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 4) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(n), 32'(exp_stalls));
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req2_valid = 1'b0;
  endtask

  // Scoreboard: pop on every response pulse, otherwise rdata must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      last1 = '0;
      last2 = '0;
    end else if (rsp_valid === 1'b1) begin
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rdata1", rdata1, e.r1);
        check("rdata2", rdata2, e.r2);
      end
      last1 = rdata1;
      last2 = rdata2;
    end else begin
      check("rdata1_hold", rdata1, last1);
      check("rdata2_hold", rdata2, last2);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req1_valid = 1'b0;  req1_we = 1'b0;  req1_addr = '0;  req1_wdata = '0;
    req2_valid = 1'b0;  req2_we = 1'b0;  req2_addr = '0;  req2_wdata = '0;
    #2;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata1", rdata1, 32'd0);
    check("reset_rdata2", rdata2, 32'd0);
    check("reset_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset during SECOND: slot1 store persists, slot2 store is dropped.
    bundle(1, 1, 12, 32'h99, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    bundle(1, 0, 12, 0, 0, 0, 0, 0, 0, 32'h99, 32'h0);
    req1_valid = 1'b1;  req1_we = 1'b1;  req1_addr = 10'd10;  req1_wdata = 32'h77;
    req2_valid = 1'b1;  req2_we = 1'b1;  req2_addr = 10'd12;  req2_wdata = 32'h88;
    @(negedge clk);
    check("t1_stall_idle", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    check("t1_rdata1_before_reset", rdata1, 32'h99);
    rst = 1'b0;
    #1;
    check("t1_stall", 32'(stall), 32'd0);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_rdata1", rdata1, 32'd0);
    check("t1_rdata2", rdata2, 32'd0);
    check("t1_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req2_valid = 1'b0;
    rst = 1'b1;
    exp_cnt = 0;
    bundle(1, 0, 10, 0, 0, 0, 0, 0, 0, 32'h77, 32'h0);
    bundle(0, 0, 0, 0, 1, 0, 12, 0, 0, 32'h0, 32'h99);

    // Split banks.
    bundle(1, 1, 4, 32'hAAAA, 1, 1, 5, 32'h5555, 0, 32'h0, 32'h0);
    bundle(1, 0, 4, 0, 1, 0, 5, 0, 0, 32'hAAAA, 32'h5555);

    // Invalid slot never writes; empty bundle produces no response.
    bundle(1, 0, 4, 0, 0, 1, 5, 32'hBAD, 0, 32'hAAAA, 32'h0);
    bundle(0, 1, 4, 32'hBAD, 0, 1, 5, 32'hBAD, 0, 32'h0, 32'h0);
    bundle(0, 0, 0, 0, 1, 0, 5, 0, 0, 32'h0, 32'h5555);

    // Same-bank conflict on two reads.
    bundle(1, 1, 2, 32'h11, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    bundle(1, 1, 6, 32'h22, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    bundle(1, 0, 2, 0, 1, 0, 6, 0, 1, 32'h11, 32'h22);
    check("t3_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    // Same-address RAW through serialisation.
    bundle(1, 1, 8, 32'hDEAD, 1, 0, 8, 0, 1, 32'h0, 32'hDEAD);
    check("t4_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    // WAW then merged same-address read.
    bundle(1, 1, 3, 32'd1, 1, 1, 3, 32'd2, 1, 32'h0, 32'h0);
    bundle(1, 0, 3, 0, 1, 0, 3, 0, 0, 32'd2, 32'd2);
    check("t5_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      bundle(1, 0, 2, 0, 1, 0, 6, 0, 1, 32'h11, 32'h22);
    end
    check("t6_cnt_saturated", 32'(conflict_cnt), 32'd15);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
